// File: rtl/pll_drp_sequencer.sv
// pll_drp_sequencer
//
// Reconfigures a PLL through its dynamic reconfiguration port (DRP). A start
// strobe puts the PLL into reset, then every entry of the selected table
// (address, keep-mask, data) is applied as a read-modify-write on the DRP.
// The PLL is then released and the sequencer waits for lock.
//
// Ports
//   DCLK      clock, all logic on the rising edge
//   RST       asynchronous active-high reset
//   SSTEP     start strobe, only accepted while idle
//   SSTATE    table select, latched together with SSTEP
//   SRDY      one-cycle pulse: reconfiguration done and PLL locked
//   BUSY      high while a sequence is in progress
//   ERR       sticky error (DRDY or lock timeout), cleared by the next start
//   ROM_ADDR  table index {sel, idx}
//   ROM_DATA  table entry {addr[6:0], keep_mask[15:0], data[15:0]}
//   DADDR/DEN/DWE/DI/DO/DRDY  DRP master port
//   LOCKED    PLL lock indicator
//   RST_PLL   reset to the PLL, high while its registers are rewritten
module pll_drp_sequencer #(
  parameter int NUM_REGS     = 23,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        DCLK,
  input  logic        RST,
  input  logic        SSTEP,
  input  logic        SSTATE,
  output logic        SRDY,
  output logic        BUSY,
  output logic        ERR,
  output logic [5:0]  ROM_ADDR,
  input  logic [38:0] ROM_DATA,
  output logic [6:0]  DADDR,
  output logic        DEN,
  output logic        DWE,
  output logic [15:0] DI,
  input  logic [15:0] DO,
  input  logic        DRDY,
  input  logic        LOCKED,
  output logic        RST_PLL
);

  // One counter serves both the DRP wait and the lock wait, so it is sized
  // for the larger of the two limits.
  localparam int MAX_WAIT = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int CNT_W    = (MAX_WAIT < 4) ? 2 : $clog2(MAX_WAIT + 1);

  localparam logic [CNT_W-1:0] DRDY_LAST   = CNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_IGNORE = CNT_W'(2);
  localparam logic [4:0]       IDX_LAST    = 5'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RD_WAIT,
    WR_WAIT,
    LOCK_WAIT
  } state_t;

  state_t           state_q;
  logic             sel_q;
  logic [4:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      mask_q;
  logic [15:0]      data_q;
  logic [6:0]       daddr_q;
  logic             den_q;
  logic             dwe_q;
  logic [15:0]      di_q;
  logic             rst_pll_q;
  logic             srdy_q;
  logic             busy_q;
  logic             err_q;

  // DRDY is only honoured from the second cycle of a wait state on, which
  // hides any acknowledge that coincides with the DEN pulse itself.
  logic        drdy_ok_d;
  logic [15:0] di_d;

  always_comb begin
    drdy_ok_d = DRDY && (cnt_q != '0);
    // Bits set in the mask keep the value read back from the PLL.
    di_d      = (DO & mask_q) | (data_q & ~mask_q);
  end

  always_ff @(posedge DCLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      daddr_q   <= '0;
      den_q     <= 1'b0;
      dwe_q     <= 1'b0;
      di_q      <= '0;
      rst_pll_q <= 1'b0;
      srdy_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // DEN/DWE and SRDY are single-cycle pulses; they fall back to zero
      // unless the current state raises them again.
      den_q  <= 1'b0;
      dwe_q  <= 1'b0;
      srdy_q <= 1'b0;
      cnt_q  <= cnt_q + CNT_W'(1);

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (SSTEP) begin
            sel_q     <= SSTATE;
            idx_q     <= '0;
            rst_pll_q <= 1'b1;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= LOAD;
          end
        end

        // ROM_ADDR has been stable for one cycle here, so ROM_DATA is valid.
        LOAD: begin
          daddr_q <= ROM_DATA[38:32];
          mask_q  <= ROM_DATA[31:16];
          data_q  <= ROM_DATA[15:0];
          den_q   <= 1'b1;
          cnt_q   <= '0;
          state_q <= RD_WAIT;
        end

        RD_WAIT: begin
          if (drdy_ok_d) begin
            di_q    <= di_d;
            den_q   <= 1'b1;
            dwe_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= WR_WAIT;
          end else if (cnt_q == DRDY_LAST) begin
            // A stuck DRP aborts the sequence and releases the PLL anyway.
            err_q     <= 1'b1;
            rst_pll_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end

        WR_WAIT: begin
          if (drdy_ok_d) begin
            cnt_q <= '0;
            if (idx_q == IDX_LAST) begin
              rst_pll_q <= 1'b0;
              state_q   <= LOCK_WAIT;
            end else begin
              idx_q   <= idx_q + 5'd1;
              state_q <= LOAD;
            end
          end else if (cnt_q == DRDY_LAST) begin
            err_q     <= 1'b1;
            rst_pll_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end

        // LOCKED may still be stale right after the PLL leaves reset, so the
        // first two cycles are skipped before trusting it.
        LOCK_WAIT: begin
          if (LOCKED && (cnt_q >= LOCK_IGNORE)) begin
            srdy_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q == LOCK_LAST) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ROM_ADDR = {sel_q, idx_q};
  assign DADDR    = daddr_q;
  assign DEN      = den_q;
  assign DWE      = dwe_q;
  assign DI       = di_q;
  assign RST_PLL  = rst_pll_q;
  assign SRDY     = srdy_q;
  assign BUSY     = busy_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_pll_drp_sequencer.sv
// tb_pll_drp_sequencer
//
// Directed bench for pll_drp_sequencer. Models the configuration table, a
// PLL DRP register file with selectable acknowledge behaviour, and a PLL lock
// output. Outputs are sampled on the falling clock edge.
module tb_pll_drp_sequencer;

  localparam int NREG = 23;

  logic        DCLK = 1'b0;
  logic        RST;
  logic        SSTEP;
  logic        SSTATE;
  logic        SRDY;
  logic        BUSY;
  logic        ERR;
  logic [5:0]  ROM_ADDR;
  logic [38:0] ROM_DATA;
  logic [6:0]  DADDR;
  logic        DEN;
  logic        DWE;
  logic [15:0] DI;
  logic [15:0] DO;
  logic        DRDY;
  logic        LOCKED;
  logic        RST_PLL;

  int tests_run;
  int tests_failed;

  always #5 DCLK = ~DCLK;

  pll_drp_sequencer #(
    .NUM_REGS    (NREG),
    .DRDY_TIMEOUT(64),
    .LOCK_TIMEOUT(100)
  ) dut (
    .DCLK    (DCLK),
    .RST     (RST),
    .SSTEP   (SSTEP),
    .SSTATE  (SSTATE),
    .SRDY    (SRDY),
    .BUSY    (BUSY),
    .ERR     (ERR),
    .ROM_ADDR(ROM_ADDR),
    .ROM_DATA(ROM_DATA),
    .DADDR   (DADDR),
    .DEN     (DEN),
    .DWE     (DWE),
    .DI      (DI),
    .DO      (DO),
    .DRDY    (DRDY),
    .LOCKED  (LOCKED),
    .RST_PLL (RST_PLL)
  );

  // Table contents: entry 0 of table 0 is the hand-computed vector, the
  // rest are distinct per index and table.
  function automatic logic [38:0] rom_fn(input logic [5:0] a);
    logic [6:0]  addr;
    logic [15:0] mask;
    logic [15:0] data;
    logic [4:0]  i;
    i = a[4:0];
    if (a == 6'd0) return {7'h08, 16'hF000, 16'h0041};
    addr = a[5] ? (7'h40 + {2'b00, i}) : (7'h08 + {2'b00, i});
    mask = 16'hF0F0 ^ {i, 3'b000, i, 3'b000};
    data = 16'h1234 + {3'b000, i, 8'h00} + {15'd0, a[5]};
    return {addr, mask, data};
  endfunction

  function automatic logic [15:0] drp_init(input logic [6:0] a);
    return (a == 7'h08) ? 16'hABCD : {a, a, 2'b10};
  endfunction

  // ---------------- environment models ----------------
  int          drp_mode;   // 0 never acknowledges, 1 acknowledges one cycle after DEN, 2 DRDY stuck high
  int          lock_mode;  // 0 never locks, 1 LOCKED stuck high, 2 locks 10 cycles after release
  logic        mem_init;
  logic [15:0] drp_mem [0:127];
  logic        den_seen;
  int          lcnt;

  always @(posedge DCLK) begin
    if (mem_init) begin
      for (int a = 0; a < 128; a++) drp_mem[a] <= drp_init(7'(a));
    end else if (DEN && DWE) begin
      drp_mem[DADDR] <= DI;
    end
    den_seen <= DEN;
    if (RST_PLL) lcnt <= 0;
    else if (lcnt < 1000) lcnt <= lcnt + 1;
  end

  assign DO       = drp_mem[DADDR];
  assign DRDY     = (drp_mode == 2) ? 1'b1 : (drp_mode == 1) ? den_seen : 1'b0;
  assign LOCKED   = (lock_mode == 1) ? 1'b1 : (lock_mode == 2) ? (!RST_PLL && lcnt >= 10) : 1'b0;
  assign ROM_DATA = rom_fn(ROM_ADDR);

  // ---------------- monitor ----------------
  int          cyc;
  logic [6:0]  acc_addr [0:1023];
  logic        acc_we   [0:1023];
  logic [15:0] acc_di   [0:1023];
  logic [5:0]  acc_rom  [0:1023];
  int          acc_cyc  [0:1023];
  int          acc_n;
  int          den_double;
  int          dwe_viol;
  int          srdy_n;
  int          srdy_cyc;
  int          fall_cyc;
  logic        srdy_busy;
  logic        den_prev;
  logic        rstpll_prev;

  always @(posedge DCLK) cyc <= cyc + 1;

  always @(negedge DCLK) begin
    if (DEN === 1'b1) begin
      if (acc_n < 1024) begin
        acc_addr[acc_n] <= DADDR;
        acc_we[acc_n]   <= DWE;
        acc_di[acc_n]   <= DI;
        acc_rom[acc_n]  <= ROM_ADDR;
        acc_cyc[acc_n]  <= cyc;
      end
      acc_n <= acc_n + 1;
      if (den_prev === 1'b1) den_double <= den_double + 1;
    end
    if (DWE === 1'b1 && DEN !== 1'b1) dwe_viol <= dwe_viol + 1;
    if (SRDY === 1'b1) begin
      srdy_n    <= srdy_n + 1;
      srdy_cyc  <= cyc;
      srdy_busy <= BUSY;
    end
    if (rstpll_prev === 1'b1 && RST_PLL === 1'b0) fall_cyc <= cyc;
    den_prev    <= DEN;
    rstpll_prev <= RST_PLL;
  end

  // Expected PLL register contents, advanced only by the bench's own model.
  logic [15:0] exp_mem [0:127];

  // ---------------- stimulus helpers ----------------
  task automatic start_seq(input logic sel, output int k);
    @(negedge DCLK);
    SSTEP  = 1'b1;
    SSTATE = sel;
    @(negedge DCLK);
    SSTEP  = 1'b0;
    k      = cyc;
  endtask

  task automatic wait_idle(input int budget, output bit to);
    int n;
    n  = 0;
    to = 1'b0;
    while (BUSY === 1'b1 && !to) begin
      if (n >= budget) to = 1'b1;
      else begin
        @(negedge DCLK);
        n++;
      end
    end
  endtask

  // Advances the expected register file over a run that completed all writes.
  task automatic model_table(input logic sel);
    logic [38:0] e;
    for (int i = 0; i < NREG; i++) begin
      e = rom_fn({sel, 5'(i)});
      exp_mem[e[38:32]] = (exp_mem[e[38:32]] & e[31:16]) | (e[15:0] & ~e[31:16]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] v [0:8];
    string       nm [0:8];
    RST = 1'b1; SSTEP = 1'b0; SSTATE = 1'b0;
    drp_mode = 1; lock_mode = 2; mem_init = 1'b1;
    repeat (3) @(negedge DCLK);
    nm = '{"DADDR", "DEN", "DWE", "DI", "RST_PLL", "SRDY", "BUSY", "ERR", "ROM_ADDR"};
    v  = '{{9'd0, DADDR}, {15'd0, DEN}, {15'd0, DWE}, DI, {15'd0, RST_PLL},
           {15'd0, SRDY}, {15'd0, BUSY}, {15'd0, ERR}, {10'd0, ROM_ADDR}};
    for (int i = 0; i < 9; i++) begin
      tests_run++;
      if (v[i] !== 16'h0) begin
        tests_failed++;
        $display("FAIL reset_%s got=%h want=0", nm[i], v[i]);
      end
    end
    mem_init = 1'b0;
    RST      = 1'b0;
    // DRDY stuck high while idle must not start anything.
    drp_mode = 2;
    repeat (4) @(negedge DCLK);
    tests_run++;
    if (BUSY !== 1'b0 || DEN !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_quiet busy=%b den=%b want 0/0", BUSY, DEN);
    end
    drp_mode = 1;
    $display("[TB] reset: done");
  endtask

  task automatic test_single_entry();
    int base, s0, k;
    bit to;
    logic [38:0] e;
    logic [15:0] w;
    drp_mode = 1; lock_mode = 2;
    base = acc_n; s0 = srdy_n;
    start_seq(1'b0, k);
    tests_run++;
    if (BUSY !== 1'b1 || RST_PLL !== 1'b1 || ROM_ADDR !== 6'h00) begin
      tests_failed++;
      $display("FAIL start_outputs busy=%b rst_pll=%b rom=%h want 1/1/00", BUSY, RST_PLL, ROM_ADDR);
    end
    wait_idle(400, to);
    tests_run++;
    if (to) begin
      tests_failed++;
      $display("FAIL single_done timed out busy=%b want 0", BUSY);
    end
    repeat (2) @(negedge DCLK);
    tests_run++;
    if (acc_addr[base] !== 7'h08 || acc_we[base] !== 1'b0 || acc_cyc[base] - k != 1) begin
      tests_failed++;
      $display("FAIL first_read addr=%h we=%b dcyc=%0d want 08/0/1", acc_addr[base], acc_we[base], acc_cyc[base] - k);
    end
    tests_run++;
    if (acc_addr[base+1] !== 7'h08 || acc_we[base+1] !== 1'b1 || acc_di[base+1] !== 16'hA041) begin
      tests_failed++;
      $display("FAIL first_write addr=%h we=%b di=%h want 08/1/a041", acc_addr[base+1], acc_we[base+1], acc_di[base+1]);
    end
    tests_run++;
    if (fall_cyc - k != 115) begin
      tests_failed++;
      $display("FAIL rst_pll_span got=%0d want 115", fall_cyc - k);
    end
    tests_run++;
    if (srdy_n - s0 != 1 || srdy_cyc - fall_cyc != 11 || srdy_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL srdy_lock count=%0d delay=%0d busy=%b want 1/11/0", srdy_n - s0, srdy_cyc - fall_cyc, srdy_busy);
    end
    tests_run++;
    if (ERR !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_err got=%b want 0", ERR);
    end
    for (int i = 0; i < NREG; i++) begin
      e = rom_fn({1'b0, 5'(i)});
      w = (exp_mem[e[38:32]] & e[31:16]) | (e[15:0] & ~e[31:16]);
      tests_run++;
      if (acc_addr[base+2*i+1] !== e[38:32] || acc_di[base+2*i+1] !== w) begin
        tests_failed++;
        $display("FAIL t0_write%0d addr=%h di=%h want %h/%h", i, acc_addr[base+2*i+1], acc_di[base+2*i+1], e[38:32], w);
      end
      exp_mem[e[38:32]] = w;
    end
    $display("[TB] single_entry: k=%0d srdy at %0d", k, srdy_cyc);
  endtask

  // Covers both the full table walk and a DRP that acknowledges every cycle.
  task automatic walk_checks(input string tag, input logic sel, input int base, input int k);
    logic [38:0] e;
    logic [15:0] w;
    for (int i = 0; i < NREG; i++) begin
      e = rom_fn({sel, 5'(i)});
      tests_run++;
      if (acc_rom[base+2*i] !== {sel, 5'(i)} || acc_addr[base+2*i] !== e[38:32] ||
          acc_we[base+2*i] !== 1'b0 || acc_cyc[base+2*i] != k + 1 + 5*i) begin
        tests_failed++;
        $display("FAIL %s_read%0d rom=%h addr=%h we=%b cyc=%0d want %h/%h/0/%0d", tag, i,
                 acc_rom[base+2*i], acc_addr[base+2*i], acc_we[base+2*i], acc_cyc[base+2*i],
                 {sel, 5'(i)}, e[38:32], k + 1 + 5*i);
      end
      w = (exp_mem[e[38:32]] & e[31:16]) | (e[15:0] & ~e[31:16]);
      tests_run++;
      if (acc_addr[base+2*i+1] !== e[38:32] || acc_we[base+2*i+1] !== 1'b1 || acc_di[base+2*i+1] !== w) begin
        tests_failed++;
        $display("FAIL %s_write%0d addr=%h we=%b di=%h want %h/1/%h", tag, i,
                 acc_addr[base+2*i+1], acc_we[base+2*i+1], acc_di[base+2*i+1], e[38:32], w);
      end
      exp_mem[e[38:32]] = w;
    end
  endtask

  task automatic test_full_table();
    int base, s0, dv0, dd0, k;
    bit to;
    drp_mode = 1; lock_mode = 1;
    base = acc_n; s0 = srdy_n; dv0 = dwe_viol; dd0 = den_double;
    start_seq(1'b1, k);
    wait_idle(400, to);
    repeat (2) @(negedge DCLK);
    tests_run++;
    if (to || acc_n - base != 46) begin
      tests_failed++;
      $display("FAIL full_den_count got=%0d timeout=%0b want 46/0", acc_n - base, to);
    end
    walk_checks("full", 1'b1, base, k);
    tests_run++;
    if (dwe_viol != dv0 || den_double != dd0) begin
      tests_failed++;
      $display("FAIL full_den_shape dwe_alone=%0d den_long=%0d want 0/0", dwe_viol - dv0, den_double - dd0);
    end
    tests_run++;
    if (fall_cyc - k != 115) begin
      tests_failed++;
      $display("FAIL full_span got=%0d want 115", fall_cyc - k);
    end
    tests_run++;
    if (srdy_n - s0 != 1 || srdy_cyc - fall_cyc != 3) begin
      tests_failed++;
      $display("FAIL full_lock_ignore count=%0d delay=%0d want 1/3", srdy_n - s0, srdy_cyc - fall_cyc);
    end
    $display("[TB] full_table: k=%0d fall at %0d", k, fall_cyc);
  endtask

  task automatic test_drdy_timeout();
    int base, s0, k;
    bit to;
    drp_mode = 0; lock_mode = 2;
    base = acc_n; s0 = srdy_n;
    start_seq(1'b0, k);
    wait_idle(200, to);
    tests_run++;
    if (to || cyc - k != 65 || ERR !== 1'b1 || RST_PLL !== 1'b0) begin
      tests_failed++;
      $display("FAIL drdy_timeout dcyc=%0d err=%b rst_pll=%b timeout=%0b want 65/1/0/0", cyc - k, ERR, RST_PLL, to);
    end
    repeat (3) @(negedge DCLK);
    tests_run++;
    if (srdy_n != s0 || acc_n - base != 1 || ERR !== 1'b1) begin
      tests_failed++;
      $display("FAIL drdy_after srdy=%0d den=%0d err=%b want 0/1/1", srdy_n - s0, acc_n - base, ERR);
    end
    drp_mode = 1;
    start_seq(1'b0, k);
    tests_run++;
    if (ERR !== 1'b0 || BUSY !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_clear err=%b busy=%b want 0/1", ERR, BUSY);
    end
    wait_idle(400, to);
    repeat (2) @(negedge DCLK);
    model_table(1'b0);
    tests_run++;
    if (to || srdy_n - s0 != 1 || ERR !== 1'b0) begin
      tests_failed++;
      $display("FAIL retry_done srdy=%0d err=%b timeout=%0b want 1/0/0", srdy_n - s0, ERR, to);
    end
    $display("[TB] drdy_timeout: done");
  endtask

  task automatic test_lock_timeout();
    int s0, k;
    bit to;
    drp_mode = 1; lock_mode = 0;
    s0 = srdy_n;
    start_seq(1'b1, k);
    wait_idle(400, to);
    tests_run++;
    if (to || cyc - fall_cyc != 100 || ERR !== 1'b1 || RST_PLL !== 1'b0) begin
      tests_failed++;
      $display("FAIL lock_timeout dcyc=%0d err=%b rst_pll=%b timeout=%0b want 100/1/0/0", cyc - fall_cyc, ERR, RST_PLL, to);
    end
    repeat (3) @(negedge DCLK);
    tests_run++;
    if (srdy_n != s0) begin
      tests_failed++;
      $display("FAIL lock_no_srdy got=%0d want 0", srdy_n - s0);
    end
    model_table(1'b1);
    lock_mode = 2;
    $display("[TB] lock_timeout: done");
  endtask

  task automatic test_back_to_back();
    int base, s0, dd0, k;
    bit to;
    drp_mode = 2; lock_mode = 2;
    base = acc_n; s0 = srdy_n; dd0 = den_double;
    start_seq(1'b0, k);
    // Repeated starts with the other table selected must be ignored.
    for (int i = 0; i < 30; i++) begin
      @(negedge DCLK);
      SSTEP  = (i % 2 == 0);
      SSTATE = 1'b1;
    end
    SSTEP = 1'b0; SSTATE = 1'b0;
    wait_idle(400, to);
    repeat (2) @(negedge DCLK);
    tests_run++;
    if (to || acc_n - base != 46 || den_double != dd0) begin
      tests_failed++;
      $display("FAIL b2b_den count=%0d den_long=%0d timeout=%0b want 46/0/0", acc_n - base, den_double - dd0, to);
    end
    walk_checks("b2b", 1'b0, base, k);
    tests_run++;
    if (srdy_n - s0 != 1 || fall_cyc - k != 115) begin
      tests_failed++;
      $display("FAIL b2b_srdy count=%0d span=%0d want 1/115", srdy_n - s0, fall_cyc - k);
    end
    drp_mode = 1;
    $display("[TB] back_to_back: k=%0d", k);
  endtask

  task automatic test_reset_mid();
    int base, s0, k, n;
    bit to;
    logic [15:0] v [0:8];
    string       nm [0:8];
    drp_mode = 1; lock_mode = 2;
    start_seq(1'b1, k);
    n = 0;
    while (!(DEN === 1'b1 && DWE === 1'b1) && n < 20) begin
      @(negedge DCLK);
      n++;
    end
    tests_run++;
    if (n >= 20) begin
      tests_failed++;
      $display("FAIL mid_find_write no write pulse within 20 cycles");
    end
    #2 RST = 1'b1;
    #1;
    nm = '{"DADDR", "DEN", "DWE", "DI", "RST_PLL", "SRDY", "BUSY", "ERR", "ROM_ADDR"};
    v  = '{{9'd0, DADDR}, {15'd0, DEN}, {15'd0, DWE}, DI, {15'd0, RST_PLL},
           {15'd0, SRDY}, {15'd0, BUSY}, {15'd0, ERR}, {10'd0, ROM_ADDR}};
    for (int i = 0; i < 9; i++) begin
      tests_run++;
      if (v[i] !== 16'h0) begin
        tests_failed++;
        $display("FAIL async_reset_%s got=%h want=0", nm[i], v[i]);
      end
    end
    @(negedge DCLK);
    RST = 1'b0;
    @(negedge DCLK);
    base = acc_n; s0 = srdy_n;
    start_seq(1'b0, k);
    wait_idle(400, to);
    repeat (2) @(negedge DCLK);
    tests_run++;
    if (to || acc_rom[base] !== 6'h00 || acc_addr[base] !== 7'h08 || acc_we[base] !== 1'b0 ||
        acc_cyc[base] - k != 1) begin
      tests_failed++;
      $display("FAIL restart_first rom=%h addr=%h we=%b dcyc=%0d want 00/08/0/1",
               acc_rom[base], acc_addr[base], acc_we[base], acc_cyc[base] - k);
    end
    walk_checks("restart", 1'b0, base, k);
    tests_run++;
    if (srdy_n - s0 != 1 || ERR !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart_srdy count=%0d err=%b want 1/0", srdy_n - s0, ERR);
    end
    $display("[TB] reset_mid: restart k=%0d", k);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int a = 0; a < 128; a++) exp_mem[a] = drp_init(7'(a));
    test_reset();
    test_single_entry();
    test_full_table();
    test_drdy_timeout();
    test_lock_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
